// File: rtl/idu_pipe.sv
// Instruction decode stage: RV32I/RV32E opcode decode, immediates, ALU operand select, illegal detect.
// Latency: 1 cycle; decoded bundle is held in a single output register.
// Backpressure: in_ready drops only while a valid bundle is held and out_ready is low; flush squashes it.
module idu_pipe #(
    parameter int XLEN   = 32,
    parameter int NR_REG = 16,
    parameter int REG_AW = $clog2(NR_REG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   reg_rdata1,
    input  logic [XLEN-1:0]   reg_rdata2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_src1,
    output logic [XLEN-1:0]   out_src2,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_store_data,
    output logic [3:0]        out_alu_op,
    output logic [2:0]        out_funct3,
    output logic              out_reg_wen,
    output logic              out_mem_ren,
    output logic              out_mem_wen,
    output logic              out_jump,
    output logic              out_branch,
    output logic              out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [5:0] NR_REG_LIM = 6'(NR_REG);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   store_data;
        logic [3:0]        alu_op;
        logic [2:0]        funct3;
        logic              reg_wen;
        logic              mem_ren;
        logic              mem_wen;
        logic              jump;
        logic              branch;
        logic              illegal;
    } bundle_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_idx;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] shamt;
    logic            shamt_ok;
    logic            load_ok;
    logic            store_ok;
    logic            use_rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            writes_rd;
    logic            bad_enc;
    logic            bad_reg;
    logic            illegal;
    logic            xfer;
    bundle_t         dec;
    bundle_t         q;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    assign opcode  = in_inst[6:0];
    assign rd_idx  = in_inst[11:7];
    assign funct3  = in_inst[14:12];
    assign rs1_idx = in_inst[19:15];
    assign rs2_idx = in_inst[24:20];
    assign funct7  = in_inst[31:25];

    assign rs1_addr = rs1_idx[REG_AW-1:0];
    assign rs2_addr = rs2_idx[REG_AW-1:0];

    // Sized casts of signed values sign-extend to XLEN.
    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    // RV32 shifts only have a 5-bit shamt, so bit 25 must be clear there.
    assign shamt    = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
    assign shamt_ok = (XLEN == 64) ? 1'b1 : !in_inst[25];

    always_comb begin
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_ok = 1'b1;
            3'b011, 3'b110:                         load_ok = (XLEN == 64);
            default:                                load_ok = 1'b0;
        endcase
        store_ok = (funct3 <= 3'b010) || ((funct3 == 3'b011) && (XLEN == 64));
    end

    always_comb begin
        dec            = '0;
        dec.pc         = in_pc;
        dec.rd         = rd_idx[REG_AW-1:0];
        dec.funct3     = funct3;
        dec.store_data = reg_rdata2;
        dec.src1       = reg_rdata1;
        dec.src2       = reg_rdata2;
        dec.alu_op     = ALU_ADD;
        use_rd         = 1'b0;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        writes_rd      = 1'b0;
        bad_enc        = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.src1  = '0;
                dec.imm   = imm_u;
                dec.src2  = imm_u;
                use_rd    = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec.src1  = in_pc;
                dec.imm   = imm_u;
                dec.src2  = imm_u;
                use_rd    = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                dec.src1  = in_pc;
                dec.src2  = XLEN'(4);
                dec.imm   = imm_j;
                dec.jump  = 1'b1;
                use_rd    = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                dec.src1  = in_pc;
                dec.src2  = XLEN'(4);
                dec.imm   = imm_i;
                dec.jump  = 1'b1;
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                bad_enc   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm    = imm_b;
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                bad_enc    = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec.imm     = imm_i;
                dec.src2    = imm_i;
                dec.mem_ren = 1'b1;
                use_rd      = 1'b1;
                use_rs1     = 1'b1;
                writes_rd   = 1'b1;
                bad_enc     = !load_ok;
            end
            OPC_STORE: begin
                dec.imm     = imm_s;
                dec.src2    = imm_s;
                dec.mem_wen = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                bad_enc     = !store_ok;
            end
            OPC_OP_IMM: begin
                dec.imm    = imm_i;
                dec.src2   = imm_i;
                dec.alu_op = alu_sel(funct3, (funct3 == 3'b101) && in_inst[30]);
                use_rd     = 1'b1;
                use_rs1    = 1'b1;
                writes_rd  = 1'b1;
                if (funct3 == 3'b001) begin
                    dec.src2 = shamt;
                    bad_enc  = (funct7[6:1] != 6'b000000) || !shamt_ok;
                end else if (funct3 == 3'b101) begin
                    dec.src2 = shamt;
                    bad_enc  = ((funct7[6:1] != 6'b000000) && (funct7[6:1] != 6'b010000)) || !shamt_ok;
                end
            end
            OPC_OP: begin
                dec.alu_op = alu_sel(funct3, in_inst[30]);
                use_rd     = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                writes_rd  = 1'b1;
                bad_enc    = !((funct7 == 7'b0000000) ||
                               ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default: bad_enc = 1'b1;
        endcase

        bad_reg = (use_rd  && ({1'b0, rd_idx}  >= NR_REG_LIM)) ||
                  (use_rs1 && ({1'b0, rs1_idx} >= NR_REG_LIM)) ||
                  (use_rs2 && ({1'b0, rs2_idx} >= NR_REG_LIM));
        illegal = bad_enc || bad_reg || (in_inst[1:0] != 2'b11);

        dec.illegal = illegal;
        dec.reg_wen = writes_rd && (rd_idx != 5'd0) && !illegal;
        if (illegal) begin
            dec.mem_ren = 1'b0;
            dec.mem_wen = 1'b0;
            dec.jump    = 1'b0;
            dec.branch  = 1'b0;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    // Flush wins over a same-cycle transfer; the bundle data may load but is never marked valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else begin
            if (xfer) begin
                q <= dec;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (xfer) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_pc         = q.pc;
    assign out_rd         = q.rd;
    assign out_src1       = q.src1;
    assign out_src2       = q.src2;
    assign out_imm        = q.imm;
    assign out_store_data = q.store_data;
    assign out_alu_op     = q.alu_op;
    assign out_funct3     = q.funct3;
    assign out_reg_wen    = q.reg_wen;
    assign out_mem_ren    = q.mem_ren;
    assign out_mem_wen    = q.mem_wen;
    assign out_jump       = q.jump;
    assign out_branch     = q.branch;
    assign out_illegal    = q.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Scoreboard bench for idu_pipe: RV32E instance for the handshake/decode table, RV64I instance for wide immediates.
module tb_idu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, reg_rdata1, reg_rdata2;
    logic [3:0]  rs1_addr, rs2_addr, out_rd, out_alu_op;
    logic [31:0] out_pc, out_src1, out_src2, out_imm, out_store_data;
    logic [2:0]  out_funct3;
    logic        out_reg_wen, out_mem_ren, out_mem_wen, out_jump, out_branch, out_illegal;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [31:0] w_in_inst;
    logic [63:0] w_in_pc, w_rdata1, w_rdata2;
    logic [4:0]  w_rs1_addr, w_rs2_addr, w_out_rd;
    logic [63:0] w_out_pc, w_out_src1, w_out_src2, w_out_imm, w_out_store_data;
    logic [3:0]  w_out_alu_op;
    logic [2:0]  w_out_funct3;
    logic        w_out_reg_wen, w_out_mem_ren, w_out_mem_wen, w_out_jump, w_out_branch, w_out_illegal;

    idu_pipe #(.XLEN(32), .NR_REG(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_src1(out_src1),
        .out_src2(out_src2), .out_imm(out_imm), .out_store_data(out_store_data),
        .out_alu_op(out_alu_op), .out_funct3(out_funct3), .out_reg_wen(out_reg_wen),
        .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen), .out_jump(out_jump),
        .out_branch(out_branch), .out_illegal(out_illegal)
    );

    idu_pipe #(.XLEN(64), .NR_REG(32)) dut64 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst),
        .in_pc(w_in_pc), .flush(1'b0), .rs1_addr(w_rs1_addr), .rs2_addr(w_rs2_addr),
        .reg_rdata1(w_rdata1), .reg_rdata2(w_rdata2), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_pc(w_out_pc), .out_rd(w_out_rd), .out_src1(w_out_src1),
        .out_src2(w_out_src2), .out_imm(w_out_imm), .out_store_data(w_out_store_data),
        .out_alu_op(w_out_alu_op), .out_funct3(w_out_funct3), .out_reg_wen(w_out_reg_wen),
        .out_mem_ren(w_out_mem_ren), .out_mem_wen(w_out_mem_wen), .out_jump(w_out_jump),
        .out_branch(w_out_branch), .out_illegal(w_out_illegal)
    );

    // flags = {reg_wen, mem_ren, mem_wen, jump, branch, illegal}; full=0 checks only pc and flags.
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  rd;
        logic [31:0] src1, src2, imm, sd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [5:0]  flags;
        logic        full;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst, pc, r1, r2;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur_exp;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [31:0] inst, pc, r1, r2, input logic [3:0] rd,
                           input logic [31:0] src1, src2, imm, input logic [3:0] alu,
                           input logic [2:0] f3, input logic [5:0] flags, input logic full);
        vec_t v;
        v.inst = inst; v.pc = pc; v.r1 = r1; v.r2 = r2;
        v.e.pc = pc; v.e.rd = rd; v.e.src1 = src1; v.e.src2 = src2; v.e.imm = imm;
        v.e.sd = r2; v.e.alu = alu; v.e.f3 = f3; v.e.flags = flags; v.e.full = full;
        vecs.push_back(v);
    endtask

    task automatic compare(input exp_t e);
        check("pc", out_pc, e.pc);
        check("flags", {out_reg_wen, out_mem_ren, out_mem_wen, out_jump, out_branch, out_illegal}, e.flags);
        if (e.full) begin
            check("rd", out_rd, e.rd);
            check("src1", out_src1, e.src1);
            check("src2", out_src2, e.src2);
            check("imm", out_imm, e.imm);
            check("alu_op", out_alu_op, e.alu);
            check("funct3", out_funct3, e.f3);
            if (e.flags[3]) check("store_data", out_store_data, e.sd);
        end
    endtask

    // Monitor: every held bundle is compared against the queue head each cycle, so stalls also prove stability.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            check("out_valid", out_valid, sb.size() != 0);
            check("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && sb.size() != 0) begin
                compare(sb[0]);
                if (out_ready) void'(sb.pop_front());
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic drive(input vec_t v);
        in_valid   = 1'b1;
        in_inst    = v.inst;
        in_pc      = v.pc;
        reg_rdata1 = v.r1;
        reg_rdata2 = v.r2;
        cur_exp    = v.e;
    endtask

    task automatic wait_xfer();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("xfer_timeout", in_ready, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; reg_rdata1 = '0; reg_rdata2 = '0; cur_exp = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_inst = '0; w_in_pc = '0; w_rdata1 = '0; w_rdata2 = '0;

        add_vec(32'hFFF10093, 32'h0,        32'd5,    32'h22,       4'd1,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 3'd0, 6'b100000, 1'b1);
        add_vec(32'h008000EF, 32'h80000000, 32'h11,   32'h22,       4'd1,  32'h80000000, 32'd4,        32'd8,        4'd0, 3'd0, 6'b100100, 1'b1);
        add_vec(32'h123452B7, 32'h80000004, 32'h11,   32'h22,       4'd5,  32'd0,        32'h12345000, 32'h12345000, 4'd0, 3'd5, 6'b100000, 1'b1);
        add_vec(32'h00312223, 32'h80000008, 32'h1000, 32'hCAFE0001, 4'd4,  32'h1000,     32'd4,        32'd4,        4'd0, 3'd2, 6'b001000, 1'b1);
        add_vec(32'h402081B3, 32'h10,       32'h11,   32'h22,       4'd3,  32'h11,       32'h22,       32'd0,        4'd1, 3'd0, 6'b100000, 1'b1);
        add_vec(32'hFE208EE3, 32'h200,      32'h11,   32'h22,       4'd13, 32'h11,       32'h22,       32'hFFFFFFFC, 4'd1, 3'd0, 6'b000010, 1'b1);
        add_vec(32'hFF812383, 32'h14,       32'h11,   32'h22,       4'd7,  32'h11,       32'hFFFFFFF8, 32'hFFFFFFF8, 4'd0, 3'd2, 6'b110000, 1'b1);
        add_vec(32'h40325213, 32'h18,       32'h11,   32'h22,       4'd4,  32'h11,       32'd3,        32'h403,      4'd7, 3'd5, 6'b100000, 1'b1);
        add_vec(32'h00001517, 32'h100,      32'h11,   32'h22,       4'd10, 32'h100,      32'h1000,     32'h1000,     4'd0, 3'd1, 6'b100000, 1'b1);
        add_vec(32'h00008067, 32'h300,      32'h11,   32'h22,       4'd0,  32'h300,      32'd4,        32'd0,        4'd0, 3'd0, 6'b000100, 1'b1);
        add_vec(32'h0020F333, 32'h1C,       32'h11,   32'h22,       4'd6,  32'h11,       32'h22,       32'd0,        4'd9, 3'd7, 6'b100000, 1'b1);
        add_vec(32'hFFF0B293, 32'h20,       32'h11,   32'h22,       4'd5,  32'h11,       32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 3'd3, 6'b100000, 1'b1);
        add_vec(32'h00000833, 32'h24,       32'h11,   32'h22,       4'd0,  32'd0,        32'd0,        32'd0,        4'd0, 3'd0, 6'b000001, 1'b0);
        add_vec(32'h011000B3, 32'h28,       32'h11,   32'h22,       4'd0,  32'd0,        32'd0,        32'd0,        4'd0, 3'd0, 6'b000001, 1'b0);
        add_vec(32'h0000000F, 32'h2C,       32'h11,   32'h22,       4'd0,  32'd0,        32'd0,        32'd0,        4'd0, 3'd0, 6'b000001, 1'b0);
        add_vec(32'h02109093, 32'h30,       32'h11,   32'h22,       4'd0,  32'd0,        32'd0,        32'd0,        4'd0, 3'd0, 6'b000001, 1'b0);
        add_vec(32'hFFF10090, 32'h34,       32'h11,   32'h22,       4'd0,  32'd0,        32'd0,        32'd0,        4'd0, 3'd0, 6'b000001, 1'b0);
        add_vec(32'h40209133, 32'h38,       32'h11,   32'h22,       4'd0,  32'd0,        32'd0,        32'd0,        4'd0, 3'd0, 6'b000001, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_src2", out_src2, 0);
        check("rst_out_flags", {out_reg_wen, out_mem_ren, out_mem_wen, out_jump, out_branch, out_illegal}, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_x64_valid", w_out_valid, 0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Back-to-back decode of the whole table.
        foreach (vecs[i]) begin
            drive(vecs[i]);
            wait_xfer();
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Stall: lui is held for three cycles while sw waits at the input.
        out_ready = 1'b0;
        drive(vecs[2]);
        wait_xfer();
        drive(vecs[3]);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_xfer();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Flush during a transfer.
        drive(vecs[0]);
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_xfer_valid", out_valid, 0);

        // Flush of a stalled bundle.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        drive(vecs[1]);
        wait_xfer();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_held_valid", out_valid, 0);

        // Reset while stalled drops the held bundle.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        drive(vecs[4]);
        wait_xfer();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_stall_valid", out_valid, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_stall_after", out_valid, 0);

        // XLEN=64, NR_REG=32 instance.
        @(posedge clk);
        #2;
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_in_inst   = 32'h80000537;
        w_in_pc     = 64'h0000000100000000;
        w_rdata1    = 64'h1;
        w_rdata2    = 64'h2;
        @(posedge clk);
        #2;
        check("x64_lui_valid", w_out_valid, 1);
        check("x64_lui_imm", w_out_imm, 64'hFFFFFFFF80000000);
        check("x64_lui_src2", w_out_src2, 64'hFFFFFFFF80000000);
        check("x64_lui_rd", w_out_rd, 10);
        w_in_inst = 32'h02109093;
        @(posedge clk);
        #2;
        check("x64_slli_src2", w_out_src2, 64'd33);
        check("x64_slli_alu", w_out_alu_op, 2);
        check("x64_slli_illegal", w_out_illegal, 0);
        w_in_inst = 32'h00000833;
        @(posedge clk);
        #2;
        check("x64_add16_illegal", w_out_illegal, 0);
        check("x64_add16_wen", w_out_reg_wen, 1);
        check("x64_add16_rd", w_out_rd, 16);
        w_in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("x64_drain_valid", w_out_valid, 0);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
